cdb_request_queue: RTL

CDB_REQUEST_QUEUE -- requirements
Module: cdb_request_queue

---
 rtl/cdb_request_queue.sv | 121 ++++++++++++
 1 files changed

// File: rtl/cdb_request_queue.sv
// ---------------------------------------------------------------------------
// cdb_request_queue
//
// Buffers completed functional-unit results in a circular FIFO and competes
// for the common data bus (CDB) through one leaf of an external arbitration
// tree. The oldest buffered result is offered each cycle. When the tree
// grants it, that result is broadcast on the CDB in the following cycle.
//
// Handshake semantics:
//   request_OUT is a pure function of occupancy and has no bypass from the
//   input side. When grant_IN is high in a cycle where request_OUT is high,
//   the head entry is popped at that edge and is broadcast for exactly one
//   cycle after it. A grant without a request has no effect. result_valid_IN
//   pushes when the queue is not full, or when it is full and popping in the
//   same cycle. Otherwise the push is dropped. flush_IN discards everything.
//   reset_IN overrides flush_IN, and flush_IN overrides push and pop.
//
// Ports:
//   clock_IN        rising-edge clock
//   reset_IN        synchronous active-high reset
//   flush_IN        mispredict flush; empties the queue
//   result_valid_IN result presented this cycle
//   result_tag_IN   tag of the presented result
//   result_data_IN  value of the presented result
//   full_OUT        queue holds DEPTH entries (stall the functional unit)
//   count_OUT       current occupancy, 0..DEPTH
//   request_OUT     arbitration request (queue non-empty)
//   grant_IN        arbitration grant, same cycle as the request
//   cdb_valid_OUT   broadcast valid (registered)
//   cdb_tag_OUT     broadcast tag (holds when not valid)
//   cdb_data_OUT    broadcast value (holds when not valid)
// ---------------------------------------------------------------------------
module cdb_request_queue #(
    parameter int DEPTH      = 4,
    parameter int TAG_WIDTH  = 6,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clock_IN,
    input  logic                    reset_IN,
    input  logic                    flush_IN,
    input  logic                    result_valid_IN,
    input  logic [TAG_WIDTH-1:0]    result_tag_IN,
    input  logic [DATA_WIDTH-1:0]   result_data_IN,
    output logic                    full_OUT,
    output logic [$clog2(DEPTH):0]  count_OUT,
    output logic                    request_OUT,
    input  logic                    grant_IN,
    output logic                    cdb_valid_OUT,
    output logic [TAG_WIDTH-1:0]    cdb_tag_OUT,
    output logic [DATA_WIDTH-1:0]   cdb_data_OUT
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Storage is not reset; occupancy alone decides which entries are live.
    logic [TAG_WIDTH-1:0]  tag_mem  [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem [DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic push_en;
    logic pop_en;

    assign count_OUT   = count;
    assign request_OUT = (count != '0);
    assign full_OUT    = (count == CNT_W'(DEPTH));

    // A push into a full queue is accepted only when the head leaves at the
    // same edge. In that case tail == head. The read of the old head and the
    // write of the new entry to that slot both use pre-edge values.
    assign pop_en  = grant_IN && request_OUT;
    assign push_en = result_valid_IN && (!full_OUT || pop_en);

    // Pointers, occupancy and the registered broadcast.
    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock_IN) begin
        if (reset_IN) begin
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            cdb_valid_OUT <= 1'b0;
            cdb_tag_OUT   <= '0;
            cdb_data_OUT  <= '0;
        end else if (flush_IN) begin
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            cdb_valid_OUT <= 1'b0;
        end else begin
            if (push_en) begin
                tail <= tail + 1'b1;
            end
            if (pop_en) begin
                head          <= head + 1'b1;
                cdb_valid_OUT <= 1'b1;
                cdb_tag_OUT   <= tag_mem[head];
                cdb_data_OUT  <= data_mem[head];
            end else begin
                cdb_valid_OUT <= 1'b0;
            end
            case ({push_en, pop_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry write. Reset and flush suppress it, so a dropped cycle leaves
    // the array untouched.
    always_ff @(posedge clock_IN) begin
        if (!reset_IN && !flush_IN && push_en) begin
            tag_mem[tail]  <= result_tag_IN;
            data_mem[tail] <= result_data_IN;
        end
    end

endmodule
